// File: rtl/rv_wb_arb.sv
// ============================================================================
// rv_wb_arb : two-master Wishbone classic arbiter (fetch = m0, load/store = m1)
// Revision  : 1.0
// ============================================================================
`default_nettype none

module rv_wb_arb #(
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_m0_adr,
  input  logic        i_m0_cyc,
  input  logic        i_m0_stb,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  input  logic [31:0] i_m1_adr,
  input  logic [31:0] i_m1_dat,
  input  logic [3:0]  i_m1_sel,
  input  logic        i_m1_we,
  input  logic        i_m1_cyc,
  input  logic        i_m1_stb,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic [31:0] o_m_dat,
  output logic [31:0] o_s_adr,
  output logic [31:0] o_s_dat,
  output logic [3:0]  o_s_sel,
  output logic        o_s_we,
  output logic        o_s_cyc,
  output logic        o_s_stb,
  input  logic [31:0] i_s_dat,
  input  logic        i_s_ack,
  input  logic        i_s_err,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  localparam int c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  // Grant states are one-hot so the state vector doubles as o_grant.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   r_last;
  logic   w_last_next;
  logic   w_req0;
  logic   w_req1;
  logic   w_own0;
  logic   w_own1;
  logic   w_fire;

  assign w_req0 = i_m0_cyc & i_m0_stb;
  assign w_req1 = i_m1_cyc & i_m1_stb;
  assign w_own0 = (r_state == GNT0);
  assign w_own1 = (r_state == GNT1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_last  <= w_last_next;
    end
  end

  // r_last holds the index of the master released most recently.
  always_comb begin
    w_state_next = r_state;
    w_last_next  = r_last;
    case (r_state)
      IDLE: begin
        if (w_req0 && w_req1) begin
          w_state_next = ((PRIORITY_MODE != 0) || !r_last) ? GNT1 : GNT0;
        end else if (w_req0) begin
          w_state_next = GNT0;
        end else if (w_req1) begin
          w_state_next = GNT1;
        end
      end
      GNT0: begin
        if (!i_m0_cyc) begin
          w_state_next = IDLE;
          w_last_next  = 1'b0;
        end
      end
      GNT1: begin
        if (!i_m1_cyc) begin
          w_state_next = IDLE;
          w_last_next  = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    o_s_adr = 32'h0;
    o_s_dat = 32'h0;
    o_s_sel = 4'h0;
    o_s_we  = 1'b0;
    o_s_cyc = 1'b0;
    o_s_stb = 1'b0;
    case (r_state)
      GNT0: begin
        o_s_adr = i_m0_adr;
        o_s_sel = 4'hF;
        o_s_cyc = i_m0_cyc;
        o_s_stb = i_m0_stb;
      end
      GNT1: begin
        o_s_adr = i_m1_adr;
        o_s_dat = i_m1_dat;
        o_s_sel = i_m1_sel;
        o_s_we  = i_m1_we;
        o_s_cyc = i_m1_cyc;
        o_s_stb = i_m1_stb;
      end
      default: ;
    endcase
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdt
      localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT_CYCLES);
      localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);
      logic [c_cnt_w-1:0] r_wdt_cnt;
      logic               w_stall;

      // A real ack or err removes the stall, so a same-cycle ack always beats the watchdog.
      assign w_stall = (w_own0 | w_own1) & o_s_stb & ~i_s_ack & ~i_s_err;
      assign w_fire  = w_stall & (r_wdt_cnt == c_limit);

      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          r_wdt_cnt <= '0;
        end else if (w_stall && !w_fire && (w_state_next != IDLE)) begin
          r_wdt_cnt <= r_wdt_cnt + c_one;
        end else begin
          r_wdt_cnt <= '0;
        end
      end
    end else begin : g_no_wdt
      assign w_fire = 1'b0;
    end
  endgenerate

  assign o_m_dat   = i_s_dat;
  assign o_m0_ack  = i_s_ack & w_own0;
  assign o_m1_ack  = i_s_ack & w_own1;
  assign o_m0_err  = (i_s_err | w_fire) & w_own0;
  assign o_m1_err  = (i_s_err | w_fire) & w_own1;
  assign o_grant   = r_state;
  assign o_timeout = w_fire;

endmodule

`default_nettype wire

// File: doc/rv_wb_arb.md
# rv_wb_arb

Two-master Wishbone classic arbiter that shares the core's single external Wishbone bus between the instruction-fetch port (master 0) and the load/store port (master 1). It sits between the core's bus-facing stages and the system interconnect. It grants one master at a time, holds the grant for the whole `cyc` burst, and routes `ack`/`err` back to the owner only. A watchdog terminates transfers the slave never acknowledges.

## Interface
- `PRIORITY_MODE`, default 0: 0 = round-robin on contention; 1 = master 1 (data) always wins contention.
- `TIMEOUT_CYCLES`, default 255: number of unacknowledged `stb` cycles before a synthesized error; 0 disables the watchdog.
- `i_clk`  in  1  system clock, rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_m0_adr`  in  32  fetch address.
- `i_m0_cyc`, `i_m0_stb`  in  1 each  fetch cycle and strobe (fetch is always a read).
- `o_m0_ack`, `o_m0_err`  out  1 each  fetch ack and error.
- `i_m1_adr`, `i_m1_dat`  in  32 each  data address and write data.
- `i_m1_sel`  in  4  byte selects.
- `i_m1_we`, `i_m1_cyc`, `i_m1_stb`  in  1 each  data write-enable, cycle and strobe.
- `o_m1_ack`, `o_m1_err`  out  1 each  data ack and error.
- `o_m_dat`  out  32  slave read data, broadcast to both masters.
- `o_s_adr`, `o_s_dat`  out  32 each  slave address and write data.
- `o_s_sel`  out  4  slave byte selects.
- `o_s_we`, `o_s_cyc`, `o_s_stb`  out  1 each  slave write-enable, cycle and strobe.
- `i_s_dat`  in  32  slave read data.
- `i_s_ack`, `i_s_err`  in  1 each  slave ack and error.
- `o_grant`  out  2  one-hot current owner: bit 0 = fetch, bit 1 = data.
- `o_timeout`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- A master requests when its `cyc & stb` is high.
- FSM states: `IDLE`, `GNT0`, `GNT1`. State is registered.
- **`IDLE`:**
  - Single request: go to that master's grant state.
  - Both request, `PRIORITY_MODE=0`: grant the master that was not granted last.
  - Both request, `PRIORITY_MODE=1`: grant master 1.
  - No request: stay in `IDLE`.
- **`GNTx`:**
  - Stay while `i_mx_cyc` is high, including gaps where `stb` is low.
  - When `i_mx_cyc` goes low, go to `IDLE` and set the last-grant flag to x.
- **Slave-side routing** (combinational from state):
  - In `GNTx`, `adr`/`sel`/`we`/`dat`/`cyc`/`stb` come from master x.
  - Fetch drives `we=0`, `sel=4'hF`, `dat=0`.
  - In `IDLE`, all slave outputs are 0.
- **Responses:** `o_mx_ack = i_s_ack & GNTx`; same rule for `err`. The non-owner never sees `ack`/`err`.
- **Watchdog:**
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
  - Increments each cycle in a grant state with `o_s_stb=1` and no `i_s_ack`/`i_s_err`.
  - Clears on `ack`, `err`, grant release, or `stb` low.
  - When the counter equals `TIMEOUT_CYCLES`: assert `o_mx_err` and `o_timeout` for one cycle, clear the counter, and keep the grant until the owner drops `cyc`.
- A slave `ack` in the same cycle the watchdog fires takes precedence: pass the `ack` and suppress the synthesized error.
- Simultaneous `i_s_ack` and `i_s_err`: pass both unchanged.

## Timing
- **Reset values:**
  - State `IDLE`; last-grant = master 1, so master 0 wins the first round-robin tie.
  - Watchdog counter 0.
  - `o_grant=0`, `o_timeout=0`, all `ack`/`err` = 0, all slave outputs 0.
- **Reset mid-transfer:** all outputs drop asynchronously. The slave sees `cyc` fall, and the transfer is abandoned.
- **Grant latency:** request seen in `IDLE` at edge N gives `GNTx` and `o_s_stb` in cycle N+1.
- **Ack path:** combinational, slave `ack` reaches the master in the same cycle.
- **Release:** owner drops `cyc` in cycle M, giving `IDLE` in M+1. The earliest next grant is M+2.
- **Fairness:** under continuous contention with `PRIORITY_MODE=0`, grants alternate 0,1,0,1.
- **Watchdog firing:** the synthesized `err` occurs in the cycle where the counter equals `TIMEOUT_CYCLES`, i.e. the (`TIMEOUT_CYCLES+1`)-th stalled strobe cycle.

## Test plan
- **Single fetch:** m0 requests `adr=0x100`; slave acks one cycle later with `dat=0x00000013`.
  - Expect `o_grant=01`, `o_s_adr=0x100`, `o_s_we=0`, `o_s_sel=F`.
  - Expect `o_m0_ack` for 1 cycle and `o_m_dat=0x00000013`; `o_m1_ack` stays 0.
- **Simultaneous request after reset, `PRIORITY_MODE=0`:** m0 and m1 both request.
  - Expect m0 granted first; m1 granted 2 cycles after m0 drops `cyc`.
  - Repeat the contention; expect m1 granted first.
- **Data priority, `PRIORITY_MODE=1`:** both request.
  - Expect m1 granted; m1 write `adr=0x2000_0004`, `dat=0xDEADBEEF`, `sel=0011` appears on the slave port unchanged.
- **Burst hold:** m1 holds `cyc` through 3 acked strobes with a `stb`-low gap while m0 requests throughout.
  - Expect `o_grant` to stay 10 until m1 drops `cyc`; no `ack` reaches m0.
- **Watchdog, `TIMEOUT_CYCLES=4`:** m0 strobes; slave never acks.
  - Expect `o_m0_err` and `o_timeout` high exactly on the 5th stalled cycle, then the counter restarts.
  - Slave `ack` arriving on the 5th cycle instead gives `ack` and no `err`.
- **Async reset mid-burst:** assert `i_reset` between clock edges while `GNT1` with `stb` high.
  - Expect `o_s_cyc`, `o_s_stb`, and `o_grant` to go 0 immediately.
  - After release, first request is granted with m0 winning a tie.
